// File: rtl/grid_kbd_pkg.sv
// Shared definitions for the keyboard-driven grid cursor controller:
// default grid geometry, PS/2 set-2 scancodes and the parser state encoding.
package grid_kbd_pkg;

  localparam int unsigned COLS_DEF  = 6;
  localparam int unsigned ROWS_DEF  = 4;
  localparam int unsigned VAL_W_DEF = 4;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    P_IDLE,
    P_EXT,
    P_BRK,
    P_EXT_BRK
  } parse_state_e;

endpackage

// File: rtl/ps2_scancode_parser.sv
// PS/2 scancode byte parser. Tracks E0/F0 prefixes and flags each completed
// make code in the cycle of its strobe; break codes and parity-failed bytes
// are discarded.
//   clk_i, rst_i     clock / async active-high reset
//   kbd_data_i       scancode byte, valid with kbd_strobe_i
//   kbd_strobe_i     one-cycle byte strobe
//   parity_error_i   drop the strobed byte and resync to idle
//   cmd_valid_o      completed make code present this cycle
//   cmd_ext_o        make code was E0-prefixed
//   cmd_code_o       the make code byte
module ps2_scancode_parser
  import grid_kbd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] kbd_data_i,
  input  logic       kbd_strobe_i,
  input  logic       parity_error_i,
  output logic       cmd_valid_o,
  output logic       cmd_ext_o,
  output logic [7:0] cmd_code_o
);

  parse_state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= P_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_o = 1'b0;
    cmd_ext_o   = 1'b0;
    cmd_code_o  = kbd_data_i;
    if (kbd_strobe_i) begin
      if (parity_error_i) begin
        state_d = P_IDLE;
      end else begin
        unique case (state_q)
          P_IDLE: begin
            if (kbd_data_i == SC_EXT)      state_d = P_EXT;
            else if (kbd_data_i == SC_BRK) state_d = P_BRK;
            else                           cmd_valid_o = 1'b1;
          end
          P_EXT: begin
            if (kbd_data_i == SC_BRK)      state_d = P_EXT_BRK;
            else if (kbd_data_i == SC_EXT) state_d = P_EXT;
            else begin
              cmd_valid_o = 1'b1;
              cmd_ext_o   = 1'b1;
              state_d     = P_IDLE;
            end
          end
          default: state_d = P_IDLE;  // P_BRK / P_EXT_BRK: swallow released key
        endcase
      end
    end
  end

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Keyboard-driven cursor and cell-value controller for the on-screen grid.
// Holds a working cursor updated by arrow keys, a frame-synchronous shadow
// cursor for display, and one VAL_W-bit value per cell edited by
// Enter/Backspace/Esc. A registered query port reports per pixel whether the
// queried cell is the cursor and what value it holds.
//   clk, rst                 pixel clock / async active-high reset
//   kbd_data, kbd_strobe,
//   parity_error             raw scancode byte interface
//   frame_tick               start of vertical blanking; loads shadow cursor
//   query_x, query_y         cell being drawn
//   cursor_x, cursor_y       displayed (shadow) cursor
//   q_is_cursor, q_val       1-cycle-latency query results
//   key_evt                  pulses with every executed command
module grid_cursor_ctrl
  import grid_kbd_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned VAL_W = VAL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_strobe,
  input  logic             parity_error,
  input  logic             frame_tick,
  input  logic [2:0]       query_x,
  input  logic [1:0]       query_y,
  output logic [2:0]       cursor_x,
  output logic [1:0]       cursor_y,
  output logic             q_is_cursor,
  output logic [VAL_W-1:0] q_val,
  output logic             key_evt
);

  localparam logic [2:0] X_MAX = 3'(COLS - 1);
  localparam logic [1:0] Y_MAX = 2'(ROWS - 1);

  logic       cmd_valid, cmd_ext;
  logic [7:0] cmd_code;

  ps2_scancode_parser u_parser (
    .clk_i          (clk),
    .rst_i          (rst),
    .kbd_data_i     (kbd_data),
    .kbd_strobe_i   (kbd_strobe),
    .parity_error_i (parity_error),
    .cmd_valid_o    (cmd_valid),
    .cmd_ext_o      (cmd_ext),
    .cmd_code_o     (cmd_code)
  );

  logic [2:0]       wx_q, wx_d, sx_q;
  logic [1:0]       wy_q, wy_d, sy_q;
  logic [VAL_W-1:0] cell_q [ROWS][COLS];
  logic [VAL_W-1:0] cell_d [ROWS][COLS];
  logic             evt_q, evt_d;
  logic             qcur_q, qcur_d;
  logic [VAL_W-1:0] qval_q, qval_d;
  logic             q_in_range;

  always_comb begin
    wx_d   = wx_q;
    wy_d   = wy_q;
    cell_d = cell_q;
    evt_d  = 1'b0;
    if (cmd_valid) begin
      if (cmd_ext) begin
        unique case (cmd_code)
          SC_UP:    begin wy_d = (wy_q == 2'd0)  ? Y_MAX : wy_q - 2'd1; evt_d = 1'b1; end
          SC_DOWN:  begin wy_d = (wy_q == Y_MAX) ? 2'd0  : wy_q + 2'd1; evt_d = 1'b1; end
          SC_LEFT:  begin wx_d = (wx_q == 3'd0)  ? X_MAX : wx_q - 3'd1; evt_d = 1'b1; end
          SC_RIGHT: begin wx_d = (wx_q == X_MAX) ? 3'd0  : wx_q + 3'd1; evt_d = 1'b1; end
          default:  ;
        endcase
      end else begin
        unique case (cmd_code)
          SC_ENTER: begin
            cell_d[wy_q][wx_q] = cell_q[wy_q][wx_q] + VAL_W'(1);
            evt_d = 1'b1;
          end
          SC_BKSP: begin
            cell_d[wy_q][wx_q] = '0;
            evt_d = 1'b1;
          end
          SC_ESC: begin
            cell_d = '{default: '0};
            wx_d   = '0;
            wy_d   = '0;
            evt_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Zero-extended compares keep the range check meaningful for any geometry.
  always_comb begin
    q_in_range = ({1'b0, query_x} < 4'(COLS)) && ({1'b0, query_y} < 3'(ROWS));
    qcur_d     = q_in_range && (query_x == sx_q) && (query_y == sy_q);
    qval_d     = '0;
    if (q_in_range) qval_d = cell_q[query_y][query_x];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wx_q   <= '0;
      wy_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      cell_q <= '{default: '0};
      evt_q  <= 1'b0;
      qcur_q <= 1'b0;
      qval_q <= '0;
    end else begin
      wx_q   <= wx_d;
      wy_q   <= wy_d;
      cell_q <= cell_d;
      evt_q  <= evt_d;
      qcur_q <= qcur_d;
      qval_q <= qval_d;
      // Sampling the registered working cursor gives the pre-command value
      // when a command lands on the same edge.
      if (frame_tick) begin
        sx_q <= wx_q;
        sy_q <= wy_q;
      end
    end
  end

  assign cursor_x    = sx_q;
  assign cursor_y    = sy_q;
  assign q_is_cursor = qcur_q;
  assign q_val       = qval_q;
  assign key_evt     = evt_q;

endmodule
